seg7_scan_mux: RTL
==================

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter DIV, default 250000, clk cycles per scan step (legal >= 1).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port load  input  1  capture request for digits_in/dp_in/blank_in.
REQ-006 SHALL have port digits_in  input  4*NUM_DIGITS  hex nibbles, digit k at bits [4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blank_in  input  NUM_DIGITS  force-blank per digit, 1 = blank.
REQ-009 SHALL have port lz_en  input  1  leading-zero suppression enable, sampled live.
REQ-010 SHALL have port cathodes  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal point segment, active-low.
REQ-012 SHALL have port anodes  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-013 SHALL have port pending  output  1  loaded data waiting for frame boundary.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when scan wraps to digit 0.

Function
REQ-015 Prescaler SHALL count 0..DIV-1; tick asserted in the cycle count == DIV-1, count then returns to 0; DIV=1 gives a tick every cycle.
REQ-016 On each tick scan index SHALL advance idx -> idx+1, NUM_DIGITS-1 wraps to 0; idx changes only on ticks.
REQ-017 All outputs SHALL be registered and updated on the tick edge, reflecting the new idx (latency one clk from tick to output).
REQ-018 anodes SHALL be all ones except bit idx = 0, unless digit idx is blanked (then all ones).
REQ-019 Decode SHALL be full hex: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-020 dp SHALL be ~active_dp[idx]; blanked digit forces cathodes=7'h7F, dp=1.
REQ-021 Digit k SHALL be blanked if active_blank[k]=1, or lz_en=1 and k>0 and active digits k..NUM_DIGITS-1 are all zero; digit 0 never suppressed by lz_en.
REQ-022 load=1 SHALL copy inputs into shadow buffer and set pending=1 next cycle; later loads before boundary overwrite the shadow (last wins).
REQ-023 On a tick wrapping idx to 0 with pending=1, shadow SHALL transfer to active buffer and pending clear; display data never changes mid-frame.
REQ-024 load coincident with a wrap tick SHALL write inputs directly to active buffer (used for that digit-0 output), pending=0.
REQ-025 frame_done SHALL pulse high exactly one cycle, the cycle after the wrap tick, once per NUM_DIGITS*DIV clocks.
REQ-026 Input changes without load SHALL have no effect on outputs (except lz_en).

Reset
REQ-027 rst=0 at a clk edge SHALL set prescaler=0, idx=NUM_DIGITS-1, anodes all ones, cathodes=7'h7F, dp=1, pending=0, frame_done=0, active and shadow digits/dp=0, active blank all ones.
REQ-028 Reset SHALL override load and tick in the same cycle; reset mid-frame discards shadow data.
REQ-029 First tick after reset release SHALL wrap idx to 0 (frame boundary, frame_done follows).

Verification (NUM_DIGITS=4, DIV=4)
REQ-030 Reset, load digits=0x12AF, dp=0, blank=0 -> after first wrap anodes cycle 1110,1101,1011,0111 every 4 clk, cathodes F,A,2,1 codes.
REQ-031 lz_en=1, digits=0x0050, blank=0 -> digits 3,2 anodes 1111 cathodes 7F; digit 1 shows 5; digit 0 shows 0.
REQ-032 Load 0x1111 mid-frame at idx=1 -> pending=1, remaining digits still old value, new value from next digit 0, pending=0.
REQ-033 Two loads before boundary (0x2222 then 0x3333) -> only 0x3333 displayed; load on wrap-tick cycle -> digit 0 immediately shows new value, pending stays 0.
REQ-034 Assert rst=0 at idx=2 with pending=1 -> next cycle all outputs at reset values, pending=0; frame_done spacing 16 clk thereafter.
REQ-035 dp_in=4'b0100, blank_in=4'b0001 -> dp=0 only while anode 2 low; digit 0 slot has anodes 1111, cathodes 7F.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment display driver.
// A prescaler produces a scan tick every DIV clocks; each tick advances the
// digit index and registers the anode, cathode and decimal-point pattern for
// the new digit. New display data is captured into a shadow buffer on load
// and only becomes visible at the next frame boundary (wrap to digit 0), so
// a frame never shows a mix of old and new data.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [6:0]              cathodes,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // Segment pattern {g,f,e,d,c,b,a}, active-low, full hexadecimal set.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tick, wrap;

  // Active (displayed) and shadow (waiting) buffers
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                    pending_q, pending_d;

  // Registered display outputs and their next values
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]              cathodes_q, cathodes_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;

  // Display-path helpers
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_above;
  logic [3:0]              sel_digit;
  logic                    sel_dp;
  logic                    sel_blank;

  // Prescaler, scan index and double-buffer next-state logic.
  // NOTE: every signal gets a default at the top of the always_comb so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    wrap         = tick && (idx_q == IDX_MAX);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    sh_digits_d  = sh_digits_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    pending_d    = pending_q;

    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    if (wrap && load) begin
      // Load on the boundary itself goes straight to the display.
      act_digits_d = digits_in;
      act_dp_d     = dp_in;
      act_blank_d  = blank_in;
      pending_d    = 1'b0;
    end else if (wrap && pending_q) begin
      act_digits_d = sh_digits_q;
      act_dp_d     = sh_dp_q;
      act_blank_d  = sh_blank_q;
      pending_d    = 1'b0;
    end else if (load) begin
      // Mid-frame load: park in the shadow, last load wins.
      sh_digits_d  = digits_in;
      sh_dp_d      = dp_in;
      sh_blank_d   = blank_in;
      pending_d    = 1'b1;
    end
  end

  // Pattern for the digit that becomes current on this tick, built from the
  // buffer contents that will be active after this edge.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    sel_digit  = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b1;
    anodes_d   = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above   = zero_above && (act_digits_d[4*k +: 4] == 4'h0);
      blank_vec[k] = act_blank_d[k] || (lz_en && (k != 0) && zero_above);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_digit   = act_digits_d[4*k +: 4];
        sel_dp      = act_dp_d[k];
        sel_blank   = blank_vec[k];
        anodes_d[k] = blank_vec[k];
      end
    end
    cathodes_d = sel_blank ? 7'h7F : hex_to_seg(sel_digit);
    dp_d       = sel_blank ? 1'b1 : ~sel_dp;
  end

  // Scan and buffer state registers with synchronous active-low reset.
  // NOTE: state registers use non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register.
  // NOTE: the buffers are small flop arrays, not RAM, and are cleared on
  // reset so the first frame shows a defined, fully blanked display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= IDX_MAX;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      pending_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      pending_q    <= pending_d;
    end
  end

  // Output registers: display pattern changes only on scan ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      anodes_q     <= '1;
      cathodes_q   <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (tick) begin
        anodes_q   <= anodes_d;
        cathodes_q <= cathodes_d;
        dp_q       <= dp_d;
      end
    end
  end

  assign anodes     = anodes_q;
  assign cathodes   = cathodes_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
